// File: rtl/sd_spi_responder.sv
// SD-card SPI-mode responder: CMD0/8/55/41/17 plus a single 512-byte block read.
// Define SD_SPI_CRC_EN to check the CRC7 of each command frame.
module sd_spi_responder #(
    parameter int unsigned NCR = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_cs,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [31:0] rd_lba,
    output logic [8:0]  rd_index,
    input  logic [7:0]  rd_data,
    output logic        card_idle,
    output logic        cmd_strobe,
    output logic [5:0]  cmd_index
);

    typedef enum logic [2:0] {
        S_HUNT, S_ARG, S_CRC, S_NCR, S_RESP, S_TOKEN, S_DATA, S_DCRC
    } state_t;

`ifdef SD_SPI_CRC_EN
    function automatic logic [6:0] crc7_bit(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] d);
        logic [6:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) r = crc7_bit(r, d[i]);
        return r;
    endfunction
`endif

    logic cs_m_q, cs_s_q, sck_m_q, sck_s_q, sck_p_q, mo_m_q, mo_s_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cs_m_q  <= 1'b1;
            cs_s_q  <= 1'b1;
            sck_m_q <= 1'b0;
            sck_s_q <= 1'b0;
            sck_p_q <= 1'b0;
            mo_m_q  <= 1'b1;
            mo_s_q  <= 1'b1;
        end else begin
            cs_m_q  <= spi_cs;
            cs_s_q  <= cs_m_q;
            sck_m_q <= spi_sclk;
            sck_s_q <= sck_m_q;
            sck_p_q <= sck_s_q;
            mo_m_q  <= spi_mosi;
            mo_s_q  <= mo_m_q;
        end
    end

    state_t      state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic [6:0]  rx_q, rx_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [8:0]  dcnt_q, dcnt_d;
    logic [39:0] resp_q, resp_d;
    logic [2:0]  rem_q, rem_d;
    logic        rdop_q, rdop_d;
    logic [7:0]  tx_q, tx_d;
    logic        miso_q, miso_d;
    logic        idle_q, idle_d;
    logic        app_q, app_d;
    logic        stb_q, stb_d;
    logic [31:0] lba_q, lba_d;
    logic [8:0]  idx_q, idx_d;
    logic [5:0]  cidx_q, cidx_d;
    logic [7:0]  r1;
    logic        crc_bad;

    logic       rise, fall, byte_end;
    logic [7:0] rx_byte;

    assign rise     = sck_s_q & ~sck_p_q & ~cs_s_q;
    assign fall     = ~sck_s_q & sck_p_q & ~cs_s_q;
    assign byte_end = rise && (bit_q == 3'd7);
    assign rx_byte  = {rx_q, mo_s_q};

`ifdef SD_SPI_CRC_EN
    logic [6:0] crc_q, crc_d;
    assign crc_bad = (crc_q != rx_byte[7:1]);
`else
    assign crc_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        rx_d    = rx_q;
        cmd_d   = cmd_q;
        arg_d   = arg_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        resp_d  = resp_q;
        rem_d   = rem_q;
        rdop_d  = rdop_q;
        tx_d    = tx_q;
        miso_d  = miso_q;
        idle_d  = idle_q;
        app_d   = app_q;
        stb_d   = 1'b0;
        lba_d   = lba_q;
        idx_d   = idx_q;
        cidx_d  = cidx_q;
        r1      = 8'hFF;
`ifdef SD_SPI_CRC_EN
        crc_d   = crc_q;
`endif
        if (cs_s_q) begin
            state_d = S_HUNT;
            bit_d   = 3'd0;
            rx_d    = 7'h7F;
            tx_d    = 8'hFF;
            miso_d  = 1'b1;
        end else begin
            // MISO changes on the falling edge so the host samples it stable on the rise
            if (fall) begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b1};
            end
            if (rise) begin
                bit_d = bit_q + 3'd1;
                rx_d  = rx_byte[6:0];
`ifdef SD_SPI_CRC_EN
                if (state_q == S_ARG) crc_d = crc7_bit(crc_q, mo_s_q);
`endif
                unique case (state_q)
                    S_HUNT: if (rx_byte[7:6] == 2'b01) begin
                        state_d = S_ARG;
                        cmd_d   = rx_byte[5:0];
                        bit_d   = 3'd0;
                        cnt_d   = 4'd0;
`ifdef SD_SPI_CRC_EN
                        crc_d   = crc7_byte(7'h00, rx_byte);
`endif
                    end
                    S_ARG: if (byte_end) begin
                        arg_d = {arg_q[23:0], rx_byte};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd3) state_d = S_CRC;
                    end
                    S_CRC: if (byte_end) begin
                        stb_d   = 1'b1;
                        cidx_d  = cmd_q;
                        rdop_d  = 1'b0;
                        rem_d   = 3'd0;
                        state_d = S_NCR;
                        cnt_d   = 4'd1;
                        tx_d    = 8'hFF;
                        if (crc_bad) begin
                            r1 = {7'b0000100, idle_q};
                        end else begin
                            unique case (cmd_q)
                                6'd0: begin
                                    idle_d = 1'b1;
                                    app_d  = 1'b0;
                                    r1     = 8'h01;
                                end
                                6'd55: begin
                                    app_d = 1'b1;
                                    r1    = {7'b0, idle_q};
                                end
                                6'd41: begin
                                    app_d = 1'b0;
                                    if (app_q) begin
                                        idle_d = 1'b0;
                                        r1     = 8'h00;
                                    end else begin
                                        r1 = {7'b0000010, idle_q};
                                    end
                                end
                                6'd17: begin
                                    app_d = 1'b0;
                                    if (idle_q) begin
                                        r1 = 8'h05;
                                    end else begin
                                        r1     = 8'h00;
                                        lba_d  = arg_q;
                                        rdop_d = 1'b1;
                                        idx_d  = 9'd0;
                                    end
                                end
                                6'd8: begin
                                    app_d = 1'b0;
                                    r1    = {7'b0, idle_q};
                                end
                                default: begin
                                    app_d = 1'b0;
                                    r1    = {7'b0000010, idle_q};
                                end
                            endcase
                        end
                        resp_d = {r1, 32'h0};
                        if (!crc_bad && cmd_q == 6'd8) begin
                            resp_d[31:0] = {20'h0, arg_q[11:0]};
                            rem_d        = 3'd4;
                        end
                    end
                    S_NCR: if (byte_end) begin
                        if (cnt_q == 4'(NCR)) begin
                            tx_d    = resp_q[39:32];
                            resp_d  = {resp_q[31:0], 8'h00};
                            state_d = S_RESP;
                        end else begin
                            tx_d  = 8'hFF;
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                    S_RESP: if (byte_end) begin
                        tx_d = 8'hFF;
                        if (rem_q != 3'd0) begin
                            tx_d   = resp_q[39:32];
                            resp_d = {resp_q[31:0], 8'h00};
                            rem_d  = rem_q - 3'd1;
                        end else if (rdop_q) begin
                            state_d = S_TOKEN;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = S_HUNT;
                            rx_d    = 7'h7F;
                        end
                    end
                    S_TOKEN: if (byte_end) begin
                        if (cnt_q == 4'd0) begin
                            tx_d  = 8'hFE;
                            cnt_d = 4'd1;
                        end else begin
                            // rd_index leads the byte on the wire by one so rd_data is settled in time
                            tx_d    = rd_data;
                            idx_d   = 9'd1;
                            dcnt_d  = 9'd0;
                            state_d = S_DATA;
                        end
                    end
                    S_DATA: if (byte_end) begin
                        if (dcnt_q == 9'd511) begin
                            tx_d    = 8'hFF;
                            cnt_d   = 4'd0;
                            state_d = S_DCRC;
                        end else begin
                            tx_d   = rd_data;
                            dcnt_d = dcnt_q + 9'd1;
                            idx_d  = (idx_q == 9'd511) ? 9'd511 : idx_q + 9'd1;
                        end
                    end
                    S_DCRC: if (byte_end) begin
                        tx_d = 8'hFF;
                        if (cnt_q == 4'd0) begin
                            cnt_d = 4'd1;
                        end else begin
                            state_d = S_HUNT;
                            rx_d    = 7'h7F;
                        end
                    end
                    default: state_d = S_HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_HUNT;
            bit_q   <= 3'd0;
            rx_q    <= 7'h7F;
            cmd_q   <= 6'd0;
            arg_q   <= 32'h0;
            cnt_q   <= 4'd0;
            dcnt_q  <= 9'd0;
            resp_q  <= 40'h0;
            rem_q   <= 3'd0;
            rdop_q  <= 1'b0;
            tx_q    <= 8'hFF;
            miso_q  <= 1'b1;
            idle_q  <= 1'b1;
            app_q   <= 1'b0;
            stb_q   <= 1'b0;
            lba_q   <= 32'h0;
            idx_q   <= 9'd0;
            cidx_q  <= 6'd0;
`ifdef SD_SPI_CRC_EN
            crc_q   <= 7'h00;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            rx_q    <= rx_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            resp_q  <= resp_d;
            rem_q   <= rem_d;
            rdop_q  <= rdop_d;
            tx_q    <= tx_d;
            miso_q  <= miso_d;
            idle_q  <= idle_d;
            app_q   <= app_d;
            stb_q   <= stb_d;
            lba_q   <= lba_d;
            idx_q   <= idx_d;
            cidx_q  <= cidx_d;
`ifdef SD_SPI_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    // Raw chip select gates MISO so a deselect is visible without synchroniser delay
    assign spi_miso   = spi_cs | miso_q;
    assign rd_lba     = lba_q;
    assign rd_index   = idx_q;
    assign card_idle  = idle_q;
    assign cmd_strobe = stb_q;
    assign cmd_index  = cidx_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: bit-banged SPI host, byte-stream reference model, strobe monitor.
module tb_sd_spi_responder;

    localparam int NCR_B = 1;
`ifdef SD_SPI_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        spi_cs = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b1;
    logic        spi_miso;
    logic [31:0] rd_lba;
    logic [8:0]  rd_index;
    logic [7:0]  rd_data, rd_p1;
    logic        card_idle;
    logic        cmd_strobe;
    logic [5:0]  cmd_index;

    sd_spi_responder #(.NCR(NCR_B)) dut (
        .clock(clock), .reset(reset), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .rd_lba(rd_lba), .rd_index(rd_index),
        .rd_data(rd_data), .card_idle(card_idle), .cmd_strobe(cmd_strobe), .cmd_index(cmd_index)
    );

    always #5 clock = ~clock;

    bit mem_xor = 1'b0;
    // Block memory with two cycles of read latency
    always @(posedge clock) begin
        rd_p1   <= rd_index[7:0] ^ (mem_xor ? rd_lba[7:0] : 8'h00);
        rd_data <= rd_p1;
    end

    int n_chk = 0, n_pass = 0, n_strobe = 0, n_frames = 0;
    logic [7:0]  exp_q[$];
    logic [5:0]  idx_q[$];
    bit          m_idle = 1'b1, m_app = 1'b0;
    logic [31:0] m_lba = 32'h0;
    logic        strobe_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (cmd_strobe) begin
            n_strobe++;
            chk("strobe_width", {31'b0, strobe_prev}, 32'd0);
            if (idx_q.size() != 0) chk("cmd_index", {26'b0, cmd_index}, {26'b0, idx_q.pop_front()});
            else chk("unexpected_strobe", {26'b0, cmd_index}, 32'hFFFF_FFFF);
        end
        strobe_prev = cmd_strobe;
    end

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            logic fb;
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // Reference: host-visible byte stream after the CRC byte, from the command rules
    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit crc_ok,
                             output bit rd);
        logic [7:0] r1;
        rd = 1'b0;
        exp_q.delete();
        repeat (NCR_B) exp_q.push_back(8'hFF);
        if (CRC_EN && !crc_ok) begin
            exp_q.push_back({7'b0000100, m_idle});
            return;
        end
        case (idx)
            6'd0:  begin m_idle = 1'b1; m_app = 1'b0; r1 = 8'h01; end
            6'd8:  begin r1 = {7'b0, m_idle}; m_app = 1'b0; end
            6'd55: begin r1 = {7'b0, m_idle}; m_app = 1'b1; end
            6'd41: begin
                if (m_app) begin m_idle = 1'b0; r1 = 8'h00; end
                else r1 = {7'b0000010, m_idle};
                m_app = 1'b0;
            end
            6'd17: begin
                m_app = 1'b0;
                if (m_idle) r1 = 8'h05;
                else begin r1 = 8'h00; rd = 1'b1; m_lba = arg; end
            end
            default: begin r1 = {7'b0000010, m_idle}; m_app = 1'b0; end
        endcase
        exp_q.push_back(r1);
        if (idx == 6'd8) begin
            exp_q.push_back(8'h00); exp_q.push_back(8'h00);
            exp_q.push_back({4'h0, arg[11:8]}); exp_q.push_back(arg[7:0]);
        end
        if (rd) begin
            exp_q.push_back(8'hFF); exp_q.push_back(8'hFE);
            for (int i = 0; i < 512; i++) exp_q.push_back(i[7:0] ^ (mem_xor ? arg[7:0] : 8'h00));
            exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #40;
            rx[i] = spi_miso;
            spi_sclk = 1'b1;
            #40;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic filler(input string tag);
        logic [7:0] rx;
        xfer(8'hFF, rx);
        chk(tag, {24'b0, rx}, 32'h0000_00FF);
    endtask

    // Sends one frame, then clocks out nresp bytes (random host data) against exp_q
    task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                             input int nresp, input string tag);
        logic [7:0] fr[6];
        logic [7:0] rx;
        fr[0] = {2'b01, idx}; fr[1] = arg[31:24]; fr[2] = arg[23:16];
        fr[3] = arg[15:8];    fr[4] = arg[7:0];   fr[5] = crc;
        idx_q.push_back(idx);
        n_frames++;
        for (int k = 0; k < 6; k++) begin
            xfer(fr[k], rx);
            chk($sformatf("%s_frame%0d", tag, k), {24'b0, rx}, 32'h0000_00FF);
        end
        for (int k = 0; k < nresp && k < exp_q.size(); k++) begin
            xfer(8'($urandom), rx);
            chk($sformatf("%s_resp%0d", tag, k), {24'b0, rx}, {24'b0, exp_q[k]});
        end
    endtask

    function automatic logic [7:0] good_crc(input logic [5:0] idx, input logic [31:0] arg);
        return {crc7({2'b01, idx, arg}), 1'b1};
    endfunction

    task automatic model_frame(input logic [5:0] idx, input logic [31:0] arg, input int extra,
                               input string tag);
        bit rd;
        model_cmd(idx, arg, 1'b1, rd);
        run_frame(idx, arg, good_crc(idx, arg), rd ? NCR_B + 3 + extra : exp_q.size(), tag);
        if (rd) begin
            spi_cs = 1'b1; #80; spi_cs = 1'b0; #80;
        end
    endtask

    initial begin
        bit rd;
        logic [5:0]  ridx;
        logic [31:0] rarg;
        #23;
        chk("rst_miso", {31'b0, spi_miso}, 32'd1);
        chk("rst_idle", {31'b0, card_idle}, 32'd1);
        chk("rst_lba", rd_lba, 32'd0);
        chk("rst_index", {23'b0, rd_index}, 32'd0);
        chk("rst_strobe", {31'b0, cmd_strobe}, 32'd0);
        chk("rst_cmd_index", {26'b0, cmd_index}, 32'd0);
        reset = 1'b0;
        #50;
        spi_cs = 1'b0;
        #40;
        filler("hunt_ff");

        model_cmd(6'd0, 32'h0, 1'b1, rd);
        exp_q = '{8'hFF, 8'h01};
        run_frame(6'd0, 32'h0, 8'h95, 2, "cmd0");
        chk("cmd0_idle", {31'b0, card_idle}, 32'd1);

        model_cmd(6'd8, 32'h0000_01AA, 1'b1, rd);
        exp_q = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        run_frame(6'd8, 32'h0000_01AA, 8'h87, 6, "cmd8");

        model_cmd(6'd17, 32'h5, 1'b1, rd);
        exp_q = '{8'hFF, 8'h05};
        run_frame(6'd17, 32'h5, good_crc(6'd17, 32'h5), 2, "cmd17_idle");
        filler("cmd17_idle_nodata");

        model_cmd(6'd55, 32'h0, 1'b1, rd);
        exp_q = '{8'hFF, 8'h01};
        run_frame(6'd55, 32'h0, good_crc(6'd55, 32'h0), 2, "cmd55");
        model_cmd(6'd41, 32'h4000_0000, 1'b1, rd);
        exp_q = '{8'hFF, 8'h00};
        run_frame(6'd41, 32'h4000_0000, good_crc(6'd41, 32'h4000_0000), 2, "cmd41");
        chk("cmd41_idle", {31'b0, card_idle}, 32'd0);

        model_cmd(6'd17, 32'h5, 1'b1, rd);
        exp_q = '{8'hFF, 8'h00, 8'hFF, 8'hFE};
        for (int i = 0; i < 512; i++) exp_q.push_back(i[7:0]);
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        run_frame(6'd17, 32'h5, good_crc(6'd17, 32'h5), 518, "read");
        chk("read_lba", rd_lba, 32'd5);
        chk("read_index_sat", {23'b0, rd_index}, 32'd511);
        filler("read_done_ff");

        model_cmd(6'd17, 32'h9, 1'b1, rd);
        run_frame(6'd17, 32'h9, good_crc(6'd17, 32'h9), NCR_B + 3 + 100, "abort");
        spi_cs = 1'b1;
        #20;
        chk("abort_miso", {31'b0, spi_miso}, 32'd1);
        chk("abort_idle", {31'b0, card_idle}, 32'd0);
        chk("abort_lba", rd_lba, 32'd9);
        #80;
        spi_cs = 1'b0;
        #40;

        model_cmd(6'd0, 32'h0, 1'b0, rd);
        exp_q = '{8'hFF, CRC_EN ? 8'h08 : 8'h01};
        run_frame(6'd0, 32'h0, 8'h00, 2, "badcrc");
        chk("badcrc_idle", {31'b0, card_idle}, CRC_EN ? 32'd0 : 32'd1);

        model_cmd(6'd0, 32'h0, 1'b1, rd);
        exp_q = '{8'hFF, 8'h01};
        run_frame(6'd0, 32'h0, 8'h95, 2, "cmd0_after");

        mem_xor = 1'b1;
        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 9))
                0:       ridx = 6'd0;
                1:       ridx = 6'd8;
                2, 3:    ridx = 6'd55;
                4, 5:    ridx = 6'd41;
                6, 7:    ridx = 6'd17;
                default: ridx = 6'($urandom_range(0, 63));
            endcase
            rarg = $urandom;
            repeat ($urandom_range(0, 2)) filler("rnd_fill");
            if ($urandom_range(0, 3) == 0) begin
                spi_cs = 1'b1; #80; spi_cs = 1'b0; #80;
            end
            model_frame(ridx, rarg, int'($urandom_range(0, 16)), $sformatf("rnd%0d_cmd%0d", it, ridx));
            chk("rnd_idle", {31'b0, card_idle}, {31'b0, m_idle});
            chk("rnd_lba", rd_lba, m_lba);
        end

        model_frame(6'd55, 32'h0, 0, "pre_rst55");
        model_cmd(6'd41, 32'h4000_0000, 1'b1, rd);
        run_frame(6'd41, 32'h4000_0000, good_crc(6'd41, 32'h4000_0000), exp_q.size(), "pre_rst41");
        model_cmd(6'd17, 32'h1234, 1'b1, rd);
        run_frame(6'd17, 32'h1234, good_crc(6'd17, 32'h1234), NCR_B + 3 + 10, "pre_rst_read");
        reset = 1'b1;
        #1;
        chk("midrst_miso", {31'b0, spi_miso}, 32'd1);
        #29;
        chk("midrst_idle", {31'b0, card_idle}, 32'd1);
        chk("midrst_lba", rd_lba, 32'd0);
        chk("midrst_index", {23'b0, rd_index}, 32'd0);
        m_idle = 1'b1; m_app = 1'b0; m_lba = 32'h0;
        reset = 1'b0;
        #60;
        filler("post_rst_ff0");
        filler("post_rst_ff1");
        model_frame(6'd0, 32'h0, 0, "post_rst_cmd0");
        chk("post_rst_idle", {31'b0, card_idle}, {31'b0, m_idle});

        #100;
        chk("strobe_count", n_strobe, n_frames);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_chk);
        $fatal(1);
    end

endmodule
